// File: rtl/usb_sie_rx_if.sv
// Receive-side SIE bundle: UTMI byte stream and address in, decoded packet events out.
`timescale 1ns/1ps
interface usb_sie_rx_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_active;
  logic        rx_error;
  logic [6:0]  dev_addr;
  logic        token_valid;
  logic [3:0]  token_pid;
  logic [3:0]  token_ep;
  logic        sof_valid;
  logic [10:0] frame_num;
  logic        hs_valid;
  logic [3:0]  hs_pid;
  logic        data_start;
  logic [3:0]  data_pid;
  logic [7:0]  data_byte;
  logic        data_byte_vld;
  logic        data_end;
  logic [10:0] data_len;
  logic        pkt_error;
  logic [2:0]  err_code;

  modport master (
    output rx_data, rx_valid, rx_active, rx_error, dev_addr,
    input  token_valid, token_pid, token_ep, sof_valid, frame_num, hs_valid, hs_pid,
           data_start, data_pid, data_byte, data_byte_vld, data_end, data_len,
           pkt_error, err_code
  );

  modport slave (
    input  rx_data, rx_valid, rx_active, rx_error, dev_addr,
    output token_valid, token_pid, token_ep, sof_valid, frame_num, hs_valid, hs_pid,
           data_start, data_pid, data_byte, data_byte_vld, data_end, data_len,
           pkt_error, err_code
  );
endinterface

// File: rtl/usb_sie_rx.sv
// USB full-speed SIE receive decoder: PID/CRC checking, token/SOF/handshake classification
// and CRC-stripped bytewise data payload streaming.
`timescale 1ns/1ps
module usb_sie_rx #(
  parameter int MAX_PKT_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  usb_sie_rx_if.slave sie
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOK1, S_TOK2, S_TOK_EOP, S_DATA, S_HS_EOP, S_DISCARD
  } state_e;

  localparam logic [2:0]  E_PID = 3'd1, E_UNSUP = 3'd2, E_CRC = 3'd3;
  localparam logic [2:0]  E_LEN = 3'd4, E_PHY = 3'd5, E_OVF = 3'd6;
  localparam logic [10:0] OVF_CNT   = 11'(MAX_PKT_SIZE + 2);
  localparam logic [4:0]  CRC5_RES  = 5'b01100;
  localparam logic [15:0] CRC16_RES = 16'h800D;
  localparam logic [3:0]  PID_SOF   = 4'b0101;

  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'b00101 : 5'b00000);
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = {c[14:0], 1'b0} ^ ((d[i] ^ c[15]) ? 16'h8005 : 16'h0000);
    return c;
  endfunction

  function automatic state_e pid_target(input logic [3:0] p);
    case (p)
      4'b0001, 4'b1001, 4'b1101, 4'b0101: pid_target = S_TOK1;
      4'b0011, 4'b1011:                   pid_target = S_DATA;
      4'b0010, 4'b1010, 4'b1110:          pid_target = S_HS_EOP;
      default:                            pid_target = S_DISCARD;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  h0_q, h0_d, h1_q, h1_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic        tok_vld_q, tok_vld_d, sof_vld_q, sof_vld_d, hs_vld_q, hs_vld_d;
  logic [3:0]  tok_pid_q, tok_pid_d, tok_ep_q, tok_ep_d, hs_pid_q, hs_pid_d;
  logic [10:0] frame_q, frame_d, dlen_q, dlen_d;
  logic        dstart_q, dstart_d, dbyte_vld_q, dbyte_vld_d, dend_q, dend_d;
  logic [3:0]  dpid_q, dpid_d;
  logic [7:0]  dbyte_q, dbyte_d;
  logic        perr_q, perr_d;
  logic [2:0]  ecode_q, ecode_d, fail_code;
  logic        byte_ok;
  state_e      pid_tgt;

  assign byte_ok = sie.rx_valid & sie.rx_active;
  assign pid_tgt = pid_target(sie.rx_data[3:0]);

  always_comb begin
    state_d = state_q;  pid_d = pid_q;  cnt_d = cnt_q;
    h0_d = h0_q;  h1_d = h1_q;  crc5_d = crc5_q;  crc16_d = crc16_q;
    fail_code = 3'd0;
    tok_vld_d = 1'b0;  tok_pid_d = tok_pid_q;  tok_ep_d = tok_ep_q;
    sof_vld_d = 1'b0;  frame_d = frame_q;
    hs_vld_d = 1'b0;   hs_pid_d = hs_pid_q;
    dstart_d = 1'b0;   dpid_d = dpid_q;  dbyte_d = dbyte_q;  dbyte_vld_d = 1'b0;
    dend_d = 1'b0;     dlen_d = dlen_q;
    perr_d = 1'b0;     ecode_d = ecode_q;

    if (state_q == S_DISCARD) begin
      if (!sie.rx_active) state_d = S_IDLE;
    end else if (state_q != S_IDLE && sie.rx_active && sie.rx_error) begin
      fail_code = E_PHY;
      state_d   = S_DISCARD;
    end else begin
      case (state_q)
        S_IDLE, S_PID: begin
          if (byte_ok) begin
            pid_d   = sie.rx_data[3:0];
            cnt_d   = '0;
            crc5_d  = 5'h1F;
            crc16_d = 16'hFFFF;
            if (sie.rx_data[7:4] != ~sie.rx_data[3:0]) begin
              fail_code = E_PID;
              state_d   = S_DISCARD;
            end else if (pid_tgt == S_DISCARD) begin
              fail_code = E_UNSUP;
              state_d   = S_DISCARD;
            end else begin
              state_d = pid_tgt;
              if (pid_tgt == S_DATA) begin
                dstart_d = 1'b1;
                dpid_d   = sie.rx_data[3:0];
              end
            end
          end else begin
            state_d = sie.rx_active ? S_PID : S_IDLE;
          end
        end
        S_TOK1, S_TOK2: begin
          if (byte_ok) begin
            h0_d    = h1_q;
            h1_d    = sie.rx_data;
            crc5_d  = crc5_byte(crc5_q, sie.rx_data);
            state_d = (state_q == S_TOK1) ? S_TOK2 : S_TOK_EOP;
          end else if (!sie.rx_active) begin
            fail_code = E_LEN;
            state_d   = S_IDLE;
          end
        end
        S_TOK_EOP: begin
          if (byte_ok) begin
            fail_code = E_LEN;
            state_d   = S_DISCARD;
          end else if (!sie.rx_active) begin
            state_d = S_IDLE;
            if (crc5_q != CRC5_RES) begin
              fail_code = E_CRC;
            end else if (pid_q == PID_SOF) begin
              sof_vld_d = 1'b1;
              frame_d   = {h1_q[2:0], h0_q};
            end else if (h0_q[6:0] == sie.dev_addr) begin
              tok_vld_d = 1'b1;
              tok_pid_d = pid_q;
              tok_ep_d  = {h1_q[2:0], h0_q[7]};
            end
          end
        end
        S_HS_EOP: begin
          if (byte_ok) begin
            fail_code = E_LEN;
            state_d   = S_DISCARD;
          end else if (!sie.rx_active) begin
            hs_vld_d = 1'b1;
            hs_pid_d = pid_q;
            state_d  = S_IDLE;
          end
        end
        S_DATA: begin
          // h0/h1 hold the two newest bytes, so a byte is released only once two more follow it
          if (byte_ok) begin
            if (cnt_q == OVF_CNT) begin
              fail_code = E_OVF;
              state_d   = S_DISCARD;
            end else begin
              h0_d    = h1_q;
              h1_d    = sie.rx_data;
              cnt_d   = cnt_q + 11'd1;
              crc16_d = crc16_byte(crc16_q, sie.rx_data);
              if (cnt_q >= 11'd2) begin
                dbyte_d     = h0_q;
                dbyte_vld_d = 1'b1;
              end
            end
          end else if (!sie.rx_active) begin
            state_d = S_IDLE;
            if (cnt_q < 11'd2) begin
              fail_code = E_LEN;
            end else if (crc16_q != CRC16_RES) begin
              fail_code = E_CRC;
            end else begin
              dend_d = 1'b1;
              dlen_d = cnt_q - 11'd2;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (fail_code != 3'd0) begin
      perr_d  = 1'b1;
      ecode_d = fail_code;
    end
  end

  always_ff @(posedge clk) begin
    h0_q    <= h0_d;
    h1_q    <= h1_d;
    crc5_q  <= crc5_d;
    crc16_q <= crc16_d;
    pid_q   <= pid_d;
    if (rst) begin
      state_q   <= S_DISCARD;
      cnt_q     <= '0;
      tok_vld_q <= 1'b0;  tok_pid_q <= '0;  tok_ep_q <= '0;
      sof_vld_q <= 1'b0;  frame_q <= '0;
      hs_vld_q  <= 1'b0;  hs_pid_q <= '0;
      dstart_q  <= 1'b0;  dpid_q <= '0;  dbyte_q <= '0;  dbyte_vld_q <= 1'b0;
      dend_q    <= 1'b0;  dlen_q <= '0;
      perr_q    <= 1'b0;  ecode_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tok_vld_q <= tok_vld_d;  tok_pid_q <= tok_pid_d;  tok_ep_q <= tok_ep_d;
      sof_vld_q <= sof_vld_d;  frame_q <= frame_d;
      hs_vld_q  <= hs_vld_d;   hs_pid_q <= hs_pid_d;
      dstart_q  <= dstart_d;   dpid_q <= dpid_d;  dbyte_q <= dbyte_d;  dbyte_vld_q <= dbyte_vld_d;
      dend_q    <= dend_d;     dlen_q <= dlen_d;
      perr_q    <= perr_d;     ecode_q <= ecode_d;
    end
  end

  assign sie.token_valid   = tok_vld_q;
  assign sie.token_pid     = tok_pid_q;
  assign sie.token_ep      = tok_ep_q;
  assign sie.sof_valid     = sof_vld_q;
  assign sie.frame_num     = frame_q;
  assign sie.hs_valid      = hs_vld_q;
  assign sie.hs_pid        = hs_pid_q;
  assign sie.data_start    = dstart_q;
  assign sie.data_pid      = dpid_q;
  assign sie.data_byte     = dbyte_q;
  assign sie.data_byte_vld = dbyte_vld_q;
  assign sie.data_end      = dend_q;
  assign sie.data_len      = dlen_q;
  assign sie.pkt_error     = perr_q;
  assign sie.err_code      = ecode_q;

endmodule

// File: tb/tb_usb_sie_rx.sv
// Testbench for usb_sie_rx: table of byte-string packets plus generated and hand-built
// corner sequences, checked against a scoreboard of expected output events.
`timescale 1ns/1ps
module tb_usb_sie_rx;

  localparam int K_NONE = 0, K_TOK = 1, K_SOF = 2, K_HS = 3, K_DST = 4;
  localparam int K_DB = 5, K_DEND = 6, K_ERR = 7;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  typedef struct {
    string      s;
    logic [6:0] addr;
    bit         dat;
    int         kind;
    int         val;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  ev_t  sbq[$];
  vec_t vecs[$];
  logic [7:0] pkt[$];

  usb_sie_rx_if bus();

  usb_sie_rx #(.MAX_PKT_SIZE(64)) dut (
    .clk (clk),
    .rst (rst),
    .sie (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic expect_ev(input int k, input int v, input string nm);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event value %0h, nothing expected", nm, v);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL %s: got kind %0d value %0h, need kind %0d value %0h", nm, k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_start)    expect_ev(K_DST,  int'(bus.data_pid), "data_start");
      if (bus.data_byte_vld) expect_ev(K_DB,   int'(bus.data_byte), "data_byte");
      if (bus.data_end)      expect_ev(K_DEND, int'(bus.data_len), "data_end");
      if (bus.pkt_error)     expect_ev(K_ERR,  int'(bus.err_code), "pkt_error");
      if (bus.token_valid)   expect_ev(K_TOK,  int'({bus.token_pid, bus.token_ep}), "token");
      if (bus.sof_valid)     expect_ev(K_SOF,  int'(bus.frame_num), "sof");
      if (bus.hs_valid)      expect_ev(K_HS,   int'(bus.hs_pid), "handshake");
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    return int'(c) - int'("a") + 10;
  endfunction

  task automatic load(input string s);
    int nib;
    logic [7:0] acc;
    nib = 0;
    acc = 8'h00;
    pkt.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == " ") continue;
      acc = {acc[3:0], 4'(hexval(s.getc(i)))};
      nib++;
      if (nib == 2) begin
        pkt.push_back(acc);
        nib = 0;
      end
    end
  endtask

  // Reflected-register CRC models producing the on-wire CRC fields.
  function automatic logic [4:0] crc5_tx(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  task automatic build_token(input logic [3:0] pid, input logic [10:0] fld);
    logic [4:0] c;
    c = crc5_tx(fld);
    pkt.delete();
    pkt.push_back({~pid, pid});
    pkt.push_back(fld[7:0]);
    pkt.push_back({c, fld[10:8]});
  endtask

  task automatic append_crc16();
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 1; i < pkt.size(); i++) begin
      b = pkt[i];
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ b[j]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    c = ~c;
    pkt.push_back(c[7:0]);
    pkt.push_back(c[15:8]);
  endtask

  task automatic send_pkt(input int gapmax, input int err_at);
    bus.rx_active = 1'b1;
    bus.rx_valid  = 1'b0;
    tick();
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(gapmax, 0)) tick();
      if (i == err_at) begin
        bus.rx_error = 1'b1;
        tick();
        bus.rx_error = 1'b0;
      end
      bus.rx_data  = pkt[i];
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
    end
    tick();
    bus.rx_active = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    repeat (3) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain %s: %0d events still pending, need 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic add(input string s, input int addr, input bit dat, input int k, input int v);
    vec_t x;
    x.s = s;  x.addr = 7'(addr);  x.dat = dat;  x.kind = k;  x.val = v;
    vecs.push_back(x);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rx_data = 8'h00;  bus.rx_valid = 1'b0;  bus.rx_error = 1'b0;
    bus.rx_active = 1'b1;  bus.dev_addr = 7'd0;

    add("69 00 10", 0, 0, K_TOK, 'h90);
    add("69 00 10", 5, 0, K_NONE, 0);
    add("C3 80 06 00 01 00 00 40 00 DD 94", 0, 1, K_DEND, 8);
    add("C3 80 06 00 01 00 00 40 00 DD 95", 0, 1, K_ERR, 3);
    add("D2", 0, 0, K_HS, 'h2);
    add("D2 00", 0, 0, K_ERR, 4);
    add("4B 00 00", 0, 1, K_DEND, 0);
    add("5A", 0, 0, K_HS, 'hA);
    add("1E", 0, 0, K_HS, 'hE);
    add("69 00", 0, 0, K_ERR, 4);
    add("69 00 10 00", 0, 0, K_ERR, 4);
    add("69 00 11", 0, 0, K_ERR, 3);
    add("3C", 0, 0, K_ERR, 2);
    add("6B", 0, 0, K_ERR, 1);
    add("C3 00", 0, 1, K_ERR, 4);
    add("", 0, 0, K_NONE, 0);

    // Reset with rx_active high: outputs clear, packet in progress dropped silently.
    repeat (3) tick();
    check("reset pulses", int'({bus.token_valid, bus.sof_valid, bus.hs_valid, bus.data_start,
                                bus.data_byte_vld, bus.data_end, bus.pkt_error}), 0);
    check("reset err_code", int'(bus.err_code), 0);
    check("reset token fields", int'({bus.token_pid, bus.token_ep}), 0);
    check("reset frame/len", int'({bus.frame_num, bus.data_len}), 0);
    rst = 1'b0;
    bus.rx_data = 8'h69;  bus.rx_valid = 1'b1;  tick();
    bus.rx_valid = 1'b0;  tick();
    bus.rx_active = 1'b0;
    drain("post-reset discard");

    for (int i = 0; i < vecs.size(); i++) begin
      bus.dev_addr = vecs[i].addr;
      load(vecs[i].s);
      if (vecs[i].dat) begin
        push(K_DST, int'(pkt[0][3:0]));
        for (int j = 1; j <= pkt.size() - 3; j++) push(K_DB, int'(pkt[j]));
      end
      if (vecs[i].kind != K_NONE) push(vecs[i].kind, vecs[i].val);
      send_pkt(1, -1);
      drain(vecs[i].s);
      if (vecs[i].kind == K_ERR) check({"err_code held ", vecs[i].s}, int'(bus.err_code), vecs[i].val);
    end

    // Generated tokens with random address/endpoint; odd ones target another address.
    for (int t = 0; t < 6; t++) begin
      logic [3:0] pid, ep;
      logic [6:0] addr;
      pid  = (t % 3 == 0) ? 4'b0001 : ((t % 3 == 1) ? 4'b1001 : 4'b1101);
      ep   = 4'($urandom_range(15, 0));
      addr = 7'($urandom_range(127, 1));
      bus.dev_addr = (t % 2 == 1) ? (addr ^ 7'h01) : addr;
      build_token(pid, {ep, addr});
      if (t % 2 == 0) push(K_TOK, int'({pid, ep}));
      send_pkt(1, -1);
      drain("generated token");
    end

    for (int t = 0; t < 3; t++) begin
      logic [10:0] fr;
      fr = (t == 0) ? 11'h000 : ((t == 1) ? 11'h7FF : 11'($urandom_range(2047, 0)));
      bus.dev_addr = 7'($urandom_range(127, 0));
      build_token(4'b0101, fr);
      push(K_SOF, int'(fr));
      send_pkt(1, -1);
      drain("generated sof");
    end

    // Data packets up to and including the maximum payload.
    for (int t = 0; t < 5; t++) begin
      int len;
      len = (t == 0) ? 1 : ((t == 1) ? 2 : ((t == 2) ? 17 : ((t == 3) ? 63 : 64)));
      pkt.delete();
      pkt.push_back((t % 2 == 0) ? 8'hC3 : 8'h4B);
      push(K_DST, (t % 2 == 0) ? 'h3 : 'hB);
      for (int j = 0; j < len; j++) begin
        pkt.push_back(8'($urandom_range(255, 0)));
        push(K_DB, int'(pkt[j + 1]));
      end
      append_crc16();
      push(K_DEND, len);
      send_pkt(1, -1);
      drain("generated data");
    end

    // PHY error mid data, then bad PID check, then a normal IN token.
    bus.dev_addr = 7'd0;
    load("C3 80 06 00 01");
    push(K_DST, 'h3);
    push(K_ERR, 5);
    send_pkt(0, 3);
    drain("rx_error in data");
    check("err_code after rx_error", int'(bus.err_code), 5);
    load("6B");
    push(K_ERR, 1);
    send_pkt(0, -1);
    drain("bad pid check");
    load("69 00 10");
    push(K_TOK, 'h90);
    send_pkt(0, -1);
    drain("in after errors");

    // Overflow: 70 payload bytes, error on the 67th byte after the PID.
    pkt.delete();
    pkt.push_back(8'hC3);
    for (int j = 0; j < 70; j++) pkt.push_back(8'($urandom_range(255, 0)));
    append_crc16();
    push(K_DST, 'h3);
    for (int j = 1; j <= 64; j++) push(K_DB, int'(pkt[j]));
    push(K_ERR, 6);
    send_pkt(1, -1);
    drain("overflow");
    check("err_code after overflow", int'(bus.err_code), 6);

    // Reset mid packet: streamed bytes before reset appear, nothing after.
    load("C3 80 06 00 01 00 44");
    push(K_DST, 'h3);
    push(K_DB, 'h80);
    push(K_DB, 'h06);
    bus.rx_active = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = pkt[i];  bus.rx_valid = 1'b1;  tick();
    end
    bus.rx_valid = 1'b0;
    tick();
    check("pre-reset scoreboard", sbq.size(), 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("err_code cleared by reset", int'(bus.err_code), 0);
    check("data_pid cleared by reset", int'(bus.data_pid), 0);
    for (int i = 5; i < 7; i++) begin
      bus.rx_data = pkt[i];  bus.rx_valid = 1'b1;  tick();
    end
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_active = 1'b0;
    drain("reset mid packet");
    load("69 00 10");
    push(K_TOK, 'h90);
    send_pkt(0, -1);
    drain("in after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
